// File: rtl/frac_clock_divider_mc_if.sv
`default_nettype none
// ============================================================================
// Module   : frac_clock_divider_mc_if
// Brief    : Shared configuration write port for the fractional divider bank.
// Revision : 1.0 - initial release
// ============================================================================
interface frac_clock_divider_mc_if #(
    parameter int W   = 30,
    parameter int CHW = 2
);
    logic           cfg_wr;
    logic [CHW-1:0] cfg_ch;
    logic [W-1:0]   cfg_n;
    logic [W-1:0]   cfg_m;
    logic [W-1:0]   cfg_phase;

    modport master (output cfg_wr, cfg_ch, cfg_n, cfg_m, cfg_phase);
    modport slave  (input  cfg_wr, cfg_ch, cfg_n, cfg_m, cfg_phase);
endinterface
`default_nettype wire

// File: rtl/frac_clock_divider_mc.sv
`default_nettype none
// ============================================================================
// Module   : frac_clock_divider_mc
// Brief    : Multi-channel fractional clock divider, f_clk*M/(2*(N+1)), with
//            double-buffered per-channel config and global phase-align sync.
// Revision : 1.0 - initial release
// ============================================================================
module frac_clock_divider_mc #(
    parameter int NCH        = 4,
    parameter int W          = 30,
    parameter bit IDLE_LEVEL = 1'b1,
    parameter int CHW        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  wire logic                    clk,
    input  wire logic                    rst_n,
    input  wire logic [NCH-1:0]          en,
    input  wire logic                    sync,
    frac_clock_divider_mc_if.slave       cfg,
    output logic      [NCH-1:0]          clk_out,
    output logic      [NCH-1:0]          tick,
    output logic      [NCH-1:0]          pending,
    output logic      [NCH-1:0]          cfg_err
);

    localparam logic [W:0] c_one = (W+1)'(1);

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic [W-1:0] r_acc;
        logic [W-1:0] r_n;
        logic [W-1:0] r_m;
        logic [W-1:0] r_ph;
        logic [W-1:0] r_sh_n;
        logic [W-1:0] r_sh_m;
        logic [W-1:0] r_sh_ph;
        logic         r_clk;
        logic         r_tick;
        logic         r_pending;
        logic         r_err;

        logic [W:0]   w_nxt;
        logic [W:0]   w_mod;
        logic [W-1:0] w_rem;
        logic         w_wrap;
        logic         w_wr;
        logic         w_apply;
        logic         w_valid;
        logic [W-1:0] w_new_n;
        logic [W-1:0] w_new_m;
        logic [W-1:0] w_new_ph;
        logic [W-1:0] w_wrap_acc;

        always_comb begin
            w_nxt   = {1'b0, r_acc} + {1'b0, r_m};
            w_mod   = {1'b0, r_n} + c_one;
            w_wrap  = (w_nxt >= w_mod);
            w_rem   = W'(w_nxt - w_mod);
            w_wr    = cfg.cfg_wr && (cfg.cfg_ch == CHW'(g));
            w_apply = r_pending && (sync || !en[g] || w_wrap);
            w_valid = ({1'b0, r_sh_m} <= ({1'b0, r_sh_n} + c_one)) &&
                      (r_sh_ph <= r_sh_n);

            w_new_n  = r_n;
            w_new_m  = r_m;
            w_new_ph = r_ph;
            if (w_apply) begin
                w_new_n  = r_sh_n;
                w_new_m  = w_valid ? r_sh_m  : '0;
                w_new_ph = w_valid ? r_sh_ph : '0;
            end

            // A shrinking modulus applied at a wrap must not leave acc above N.
            w_wrap_acc = (w_rem <= w_new_n) ? w_rem : '0;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_acc     <= '0;
                r_n       <= '0;
                r_m       <= '0;
                r_ph      <= '0;
                r_sh_n    <= '0;
                r_sh_m    <= '0;
                r_sh_ph   <= '0;
                r_clk     <= IDLE_LEVEL;
                r_tick    <= 1'b0;
                r_pending <= 1'b0;
                r_err     <= 1'b0;
            end else begin
                if (w_wr) begin
                    r_sh_n  <= cfg.cfg_n;
                    r_sh_m  <= cfg.cfg_m;
                    r_sh_ph <= cfg.cfg_phase;
                end

                // A write in the apply cycle lands in the shadow and stays pending.
                if (w_wr) begin
                    r_pending <= 1'b1;
                end else if (w_apply) begin
                    r_pending <= 1'b0;
                end

                if (w_apply) begin
                    r_n   <= w_new_n;
                    r_m   <= w_new_m;
                    r_ph  <= w_new_ph;
                    r_err <= !w_valid;
                end

                if (sync || !en[g]) begin
                    r_acc  <= w_new_ph;
                    r_clk  <= IDLE_LEVEL;
                    r_tick <= 1'b0;
                end else if (w_wrap) begin
                    r_acc  <= w_wrap_acc;
                    r_clk  <= ~r_clk;
                    r_tick <= 1'b1;
                end else begin
                    r_acc  <= w_nxt[W-1:0];
                    r_tick <= 1'b0;
                end
            end
        end

        assign clk_out[g] = r_clk;
        assign tick[g]    = r_tick;
        assign pending[g] = r_pending;
        assign cfg_err[g] = r_err;
    end

endmodule
`default_nettype wire

// File: tb/tb_frac_clock_divider_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_frac_clock_divider_mc
// Brief    : Self-checking bench for frac_clock_divider_mc (NCH=4, W=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_frac_clock_divider_mc;

    localparam int NCH = 4;
    localparam int W   = 16;
    localparam int CHW = 2;

    typedef struct {
        int ch;
        int n;
        int m;
        int ph;
        int exp_err;
        int exp_first;
        int exp_cnt;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NCH-1:0] en;
    logic           sync;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] pending;
    logic [NCH-1:0] cfg_err;

    int checks = 0;
    int errors = 0;

    vec_t tbl [10];
    vec_t sb_q [$];
    int   sb_bits [$];

    frac_clock_divider_mc_if #(.W(W), .CHW(CHW)) cfg_if ();

    frac_clock_divider_mc #(
        .NCH        (NCH),
        .W          (W),
        .IDLE_LEVEL (1'b1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .sync    (sync),
        .cfg     (cfg_if),
        .clk_out (clk_out),
        .tick    (tick),
        .pending (pending),
        .cfg_err (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cfg(input int ch, input int n, input int m, input int ph);
        cfg_if.cfg_wr    = 1'b1;
        cfg_if.cfg_ch    = CHW'(ch);
        cfg_if.cfg_n     = W'(n);
        cfg_if.cfg_m     = W'(m);
        cfg_if.cfg_phase = W'(ph);
    endtask

    // Write one channel while it is disabled so the config applies next cycle.
    task automatic load_cfg(input int ch, input int n, input int m, input int ph);
        drive_cfg(ch, n, m, ph);
        cyc();
        cfg_if.cfg_wr = 1'b0;
        cyc();
    endtask

    initial begin
        vec_t           v;
        vec_t           e;
        int             first;
        int             cnt;
        int             oth;
        int             exp;
        logic [NCH-1:0] mask;

        //          ch  n      m      ph err first cnt
        tbl[0] = '{0,     4,     1, 0, 0, 5,  6};
        tbl[1] = '{1,     9,     3, 0, 0, 4,  9};
        tbl[2] = '{2,     4,     7, 0, 1, 0,  0};
        tbl[3] = '{2,     4,     5, 0, 0, 1, 30};
        tbl[4] = '{3,     4,     1, 5, 1, 0,  0};
        tbl[5] = '{3,     4,     1, 2, 0, 3,  6};
        tbl[6] = '{0,     0,     1, 0, 0, 1, 30};
        tbl[7] = '{1, 65535, 65535, 3, 0, 1, 29};
        tbl[8] = '{2,     2,     2, 1, 0, 1, 20};
        tbl[9] = '{3,     4,     0, 0, 0, 0,  0};

        rst_n            = 1'b0;
        en               = '0;
        sync             = 1'b0;
        cfg_if.cfg_wr    = 1'b0;
        cfg_if.cfg_ch    = '0;
        cfg_if.cfg_n     = '0;
        cfg_if.cfg_m     = '0;
        cfg_if.cfg_phase = '0;

        #12;
        check("rst_clk_out", int'(clk_out), 4'hF);
        check("rst_tick",    int'(tick),    0);
        check("rst_pending", int'(pending), 0);
        check("rst_cfg_err", int'(cfg_err), 0);
        rst_n = 1'b1;
        cyc();
        check("post_rst_clk_out", int'(clk_out), 4'hF);

        // Table: load with en low, then run the channel alone for 30 edges.
        for (int i = 0; i < 10; i++) begin
            v    = tbl[i];
            en   = '0;
            mask = NCH'(1) << v.ch;
            sb_q.push_back(v);
            drive_cfg(v.ch, v.n, v.m, v.ph);
            cyc();
            cfg_if.cfg_wr = 1'b0;
            check("pend_set", int'(pending[v.ch]), 1);
            cyc();
            check("pend_clr",  int'(pending[v.ch]), 0);
            check("cfg_err",   int'(cfg_err[v.ch]), v.exp_err);
            check("idle_out",  int'(clk_out), 4'hF);
            en[v.ch] = 1'b1;
            first = 0;
            cnt   = 0;
            oth   = 0;
            for (int k = 1; k <= 30; k++) begin
                cyc();
                if (tick[v.ch]) begin
                    cnt++;
                    if (first == 0) first = k;
                end
                if ((tick & ~mask) != '0) oth++;
            end
            e = sb_q.pop_front();
            check("first_tick",  first, e.exp_first);
            check("tick_count",  cnt,   e.exp_cnt);
            check("final_level", int'(clk_out[e.ch]), (e.exp_cnt % 2 == 0) ? 1 : 0);
            check("others_quiet", oth + int'((clk_out | mask) != 4'hF), 0);
        end

        // Mid-period rate change on ch0: old half-period finishes, then 2-cycle.
        en = '0;
        load_cfg(0, 4, 1, 0);
        en = 4'b0001;
        for (int k = 1; k <= 16; k++) begin
            if (k == 8) drive_cfg(0, 1, 1, 0);
            else        cfg_if.cfg_wr = 1'b0;
            exp = ((k == 8 || k == 9) ? 2 : 0) |
                  ((k == 5 || k == 10 || k == 12 || k == 14 || k == 16) ? 1 : 0);
            sb_bits.push_back(exp);
            cyc();
            check("rate_chg", int'({pending[0], tick[0]}), sb_bits.pop_front());
        end
        cfg_if.cfg_wr = 1'b0;
        check("rate_chg_level", int'(clk_out[0]), 0);

        // Apply and write in the same cycle on ch3.
        en = '0;
        drive_cfg(3, 4, 7, 0);
        cyc();
        check("dual_pend_a", int'(pending[3]), 1);
        drive_cfg(3, 4, 1, 0);
        cyc();
        cfg_if.cfg_wr = 1'b0;
        check("dual_err_old",  int'(cfg_err[3]), 1);
        check("dual_pend_b",   int'(pending[3]), 1);
        cyc();
        check("dual_err_new",  int'(cfg_err[3]), 0);
        check("dual_pend_clr", int'(pending[3]), 0);

        // Sync phase alignment of ch0 (phase 0) and ch1 (phase 2).
        en = '0;
        load_cfg(0, 4, 1, 0);
        load_cfg(1, 4, 1, 2);
        en = 4'b0011;
        for (int k = 0; k < 7; k++) cyc();
        sync = 1'b1;
        cyc();
        sync = 1'b0;
        check("sync_clk_out", int'(clk_out[1:0]), 3);
        check("sync_tick",    int'(tick), 0);
        for (int k = 1; k <= 100; k++) begin
            sb_bits.push_back(((k % 5 == 3) ? 2 : 0) | ((k % 5 == 0) ? 1 : 0));
            cyc();
            check("sync_offset", int'(tick[1:0]), sb_bits.pop_front());
        end

        // Async reset between edges clears everything immediately.
        drive_cfg(0, 2, 1, 0);
        cyc();
        cfg_if.cfg_wr = 1'b0;
        cyc();
        cyc();
        check("pre_rst_pend", int'(pending[0]), 1);
        check("pre_rst_ch1",  int'({clk_out[1], tick[1]}), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clk_out", int'(clk_out), 4'hF);
        check("async_tick",    int'(tick),    0);
        check("async_pending", int'(pending), 0);
        check("async_cfg_err", int'(cfg_err), 0);
        #10;
        rst_n = 1'b1;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
